// File: rtl/uart_echo_responder.sv
// UART echo responder: buffers error-free received bytes in a small FIFO
// and replays them to the transmitter one frame at a time, in arrival order.
module uart_echo_responder #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   rx_done_flag,
  input  logic [7:0]             rx_data,
  input  logic [2:0]             rx_error,
  input  logic                   tx_active_flag,
  input  logic                   tx_done_flag,
  output logic                   send,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             err_count,
  output logic [7:0]             drop_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          rx_done_q;
  logic          tx_done_q;
  logic          rx_evt;
  logic          tx_evt;
  logic          rx_good;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  assign rx_evt  = rx_done_flag & ~rx_done_q;
  assign tx_evt  = tx_done_flag & ~tx_done_q;
  assign rx_good = rx_evt & (rx_error == 3'b000);
  assign full    = (fifo_level == FULL_LEVEL);
  assign empty   = (fifo_level == '0);
  // A pop in the same cycle frees the head slot, so a push at full is legal then.
  assign push    = rx_good & (~full | pop);
  assign busy    = ~empty | (state_q != IDLE);

  // Next-state logic and FIFO pop decision for the transmit handshake.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_active_flag) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_active_flag) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_evt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since level/pointers qualify them.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // State register, edge detectors, registered transmit outputs and FIFO bookkeeping.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      send       <= 1'b0;
      tx_data    <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      state_q   <= state_d;
      rx_done_q <= rx_done_flag;
      tx_done_q <= tx_done_flag;
      send      <= (state_d == SEND);
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Saturating counters for errored receptions and overflow drops.
  always_ff @(posedge clock) begin
    if (rst) begin
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (rx_evt && (rx_error != 3'b000) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      if (rx_good && !push && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
